// File: rtl/beam_interlock_sequencer_if.sv
// Signal bundle between the beam interlock sequencer and its gantry/operator environment.
// master drives sensor and request levels; slave is the sequencer itself.
interface beam_interlock_sequencer_if #(
  parameter int NUM_AUX = 2
);
  logic               xray_req;
  logic               dose_limit;
  logic               pos_ok;
  logic               temp_hi;
  logic               vib_hi;
  logic               power_fail;
  logic [NUM_AUX-1:0] aux_fault;
  logic               fault_clear;
  logic               table_en;
  logic               gantry_en;
  logic               filter_en;
  logic               fan_en;
  logic               shutter_open;
  logic               relay_iso;
  logic [3:0]         fault_code;
  logic [2:0]         state_dbg;

  modport master (
    output xray_req, dose_limit, pos_ok, temp_hi, vib_hi, power_fail, aux_fault, fault_clear,
    input  table_en, gantry_en, filter_en, fan_en, shutter_open, relay_iso, fault_code, state_dbg
  );

  modport slave (
    input  xray_req, dose_limit, pos_ok, temp_hi, vib_hi, power_fail, aux_fault, fault_clear,
    output table_en, gantry_en, filter_en, fan_en, shutter_open, relay_iso, fault_code, state_dbg
  );
endinterface

// File: rtl/beam_interlock_sequencer.sv
// One-shot X-ray beam sequencer: position, arm filter, open shutter, cool down,
// with debounced environmental sensors and a first-cause fault latch.
module beam_interlock_sequencer #(
  parameter int NUM_AUX     = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int ARM_CYCLES  = 2,
  parameter int COOL_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  beam_interlock_sequencer_if.slave   bif
);

  localparam int NF = NUM_AUX + 2;
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int AW = $clog2(ARM_CYCLES + 1);
  localparam int CW = $clog2(COOL_CYCLES + 1);

  localparam logic [2:0] S_IDLE     = 3'b000;
  localparam logic [2:0] S_POSITION = 3'b001;
  localparam logic [2:0] S_ARMED    = 3'b010;
  localparam logic [2:0] S_BEAM     = 3'b011;
  localparam logic [2:0] S_COOLDOWN = 3'b100;
  localparam logic [2:0] S_FAULT    = 3'b101;

  logic [NF-1:0]         raw;
  logic [NF-1:0]         deb_q, deb_d;
  logic [NF-1:0][DW-1:0] cnt_q, cnt_d;
  logic [2:0]            state_q, state_d;
  logic [AW-1:0]         arm_q, arm_d;
  logic [CW-1:0]         cool_q, cool_d;
  logic [3:0]            code_q, code_d;

  logic               temp_f, vib_f;
  logic [NUM_AUX-1:0] aux_f;
  logic               in_beam, pos_lost, fault_cond, any_fault_src;
  logic [3:0]         code_sel;

  // Bit 0 temp, bit 1 vibration, then the auxiliary inputs.
  assign raw    = {bif.aux_fault, bif.vib_hi, bif.temp_hi};
  assign temp_f = deb_q[0];
  assign vib_f  = deb_q[1];
  assign aux_f  = deb_q[NF-1:2];

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NF; i++) begin
      cnt_d[i] = '0;
      if (raw[i] != deb_q[i]) begin
        if (cnt_q[i] == DW'(DEB_CYCLES - 1)) deb_d[i] = raw[i];
        else                                 cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign in_beam       = (state_q == S_BEAM);
  assign pos_lost      = !bif.pos_ok && ((state_q == S_ARMED) || in_beam);
  assign fault_cond    = bif.power_fail || vib_f || (|aux_f) || (temp_f && in_beam);
  assign any_fault_src = bif.power_fail || vib_f || (|aux_f) || temp_f;

  // Highest-priority cause wins; the chain is written lowest-first so later ifs override.
  always_comb begin
    code_sel = 4'hF;
    for (int i = NUM_AUX - 1; i >= 0; i--) begin
      if (aux_f[i]) code_sel = 4'(5 + i);
    end
    if (pos_lost)          code_sel = 4'd4;
    if (temp_f && in_beam) code_sel = 4'd3;
    if (vib_f)             code_sel = 4'd2;
    if (bif.power_fail)    code_sel = 4'd1;
  end

  always_comb begin
    logic go_fault;
    go_fault = 1'b0;
    state_d  = state_q;
    arm_d    = arm_q;
    cool_d   = cool_q;
    code_d   = code_q;
    case (state_q)
      S_IDLE: begin
        if (fault_cond)        go_fault = 1'b1;
        else if (bif.xray_req) state_d  = S_POSITION;
      end
      S_POSITION: begin
        if (fault_cond) go_fault = 1'b1;
        else if (bif.pos_ok && bif.xray_req) begin
          state_d = S_ARMED;
          arm_d   = '0;
        end else if (!bif.xray_req) state_d = S_IDLE;
      end
      S_ARMED: begin
        if (fault_cond || pos_lost)          go_fault = 1'b1;
        else if (!bif.xray_req)              state_d  = S_IDLE;
        else if (arm_q == AW'(ARM_CYCLES - 1)) state_d = S_BEAM;
        else                                 arm_d    = arm_q + 1'b1;
      end
      S_BEAM: begin
        if (fault_cond || pos_lost) go_fault = 1'b1;
        else if (bif.dose_limit || !bif.xray_req) begin
          state_d = S_COOLDOWN;
          cool_d  = '0;
        end
      end
      S_COOLDOWN: begin
        if (fault_cond) go_fault = 1'b1;
        else if (cool_q >= CW'(COOL_CYCLES - 1)) begin
          if (!temp_f) state_d = S_IDLE;
        end else cool_d = cool_q + 1'b1;
      end
      S_FAULT: begin
        if (bif.fault_clear && !any_fault_src) begin
          state_d = S_IDLE;
          code_d  = 4'd0;
        end
      end
      default: go_fault = 1'b1;
    endcase
    if (go_fault) begin
      state_d = S_FAULT;
      code_d  = code_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q   <= '0;
      cnt_q   <= '0;
      state_q <= S_IDLE;
      arm_q   <= '0;
      cool_q  <= '0;
      code_q  <= '0;
    end else begin
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      arm_q   <= arm_d;
      cool_q  <= cool_d;
      code_q  <= code_d;
    end
  end

  // Actuators decode only from registered state and flags.
  assign bif.table_en     = (state_q == S_POSITION) || (state_q == S_ARMED) || in_beam;
  assign bif.gantry_en    = (state_q == S_POSITION) || (state_q == S_ARMED) || in_beam;
  assign bif.filter_en    = (state_q == S_ARMED) || in_beam;
  assign bif.shutter_open = in_beam;
  assign bif.relay_iso    = (state_q == S_FAULT);
  assign bif.fan_en       = (state_q == S_COOLDOWN) || (state_q == S_FAULT) || temp_f;
  assign bif.fault_code   = code_q;
  assign bif.state_dbg    = state_q;

endmodule

// File: tb/tb_beam_interlock_sequencer.sv
// Bench for beam_interlock_sequencer: directed shots plus random traffic,
// every cycle compared against a cycle-counting behavioural model.
module tb_beam_interlock_sequencer;

  localparam int NUM_AUX = 3;
  localparam int DEB     = 4;
  localparam int ARM     = 2;
  localparam int COOL    = 16;
  localparam int NF      = NUM_AUX + 2;

  localparam int ST_IDLE = 0, ST_POS = 1, ST_ARMED = 2, ST_BEAM = 3, ST_COOL = 4, ST_FAULT = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  beam_interlock_sequencer_if #(.NUM_AUX(NUM_AUX)) bif ();

  beam_interlock_sequencer #(
    .NUM_AUX(NUM_AUX), .DEB_CYCLES(DEB), .ARM_CYCLES(ARM), .COOL_CYCLES(COOL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bif(bif)
  );

  int n_chk = 0;
  int n_bad = 0;

  int m_st, m_arm, m_cool, m_code;
  bit m_flag [NF];
  int m_run  [NF];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = ST_IDLE; m_arm = 0; m_cool = 0; m_code = 0;
    for (int i = 0; i < NF; i++) begin
      m_flag[i] = 1'b0;
      m_run[i]  = 0;
    end
  endtask

  function automatic bit raw_in(input int i);
    if (i == 0) return bif.temp_hi;
    if (i == 1) return bif.vib_hi;
    return bif.aux_fault[i-2];
  endfunction

  // Apply one clock edge of the rules to the model, using pre-edge flags.
  task automatic model_step();
    bit tf, vf, af, pf, pl, fc, gof;
    int code, nst;
    tf = m_flag[0];
    vf = m_flag[1];
    af = 1'b0;
    for (int i = 2; i < NF; i++) af |= m_flag[i];
    pf = bif.power_fail;
    pl = !bif.pos_ok && (m_st == ST_ARMED || m_st == ST_BEAM);
    fc = pf || vf || af || (tf && m_st == ST_BEAM);
    code = 15;
    if (pf)                       code = 1;
    else if (vf)                  code = 2;
    else if (tf && m_st == ST_BEAM) code = 3;
    else if (pl)                  code = 4;
    else begin
      for (int i = NUM_AUX - 1; i >= 0; i--) if (m_flag[i+2]) code = 5 + i;
    end
    nst = m_st;
    gof = 1'b0;
    case (m_st)
      ST_IDLE:  if (fc) gof = 1; else if (bif.xray_req) nst = ST_POS;
      ST_POS: begin
        if (fc) gof = 1;
        else if (bif.pos_ok && bif.xray_req) begin nst = ST_ARMED; m_arm = 0; end
        else if (!bif.xray_req) nst = ST_IDLE;
      end
      ST_ARMED: begin
        if (fc || pl) gof = 1;
        else if (!bif.xray_req) nst = ST_IDLE;
        else begin
          m_arm++;
          if (m_arm >= ARM) nst = ST_BEAM;
        end
      end
      ST_BEAM: begin
        if (fc || pl) gof = 1;
        else if (bif.dose_limit || !bif.xray_req) begin nst = ST_COOL; m_cool = 0; end
      end
      ST_COOL: begin
        if (fc) gof = 1;
        else begin
          if (m_cool < COOL) m_cool++;
          if (m_cool >= COOL && !tf) nst = ST_IDLE;
        end
      end
      default: begin
        if (bif.fault_clear && !(pf || vf || af || tf)) begin nst = ST_IDLE; m_code = 0; end
      end
    endcase
    if (gof) begin nst = ST_FAULT; m_code = code; end
    m_st = nst;
    for (int i = 0; i < NF; i++) begin
      if (raw_in(i) != m_flag[i]) begin
        m_run[i]++;
        if (m_run[i] >= DEB) begin m_flag[i] = raw_in(i); m_run[i] = 0; end
      end else m_run[i] = 0;
    end
  endtask

  function automatic logic [5:0] exp_outs();
    logic [5:0] v;
    v[5] = (m_st == ST_POS || m_st == ST_ARMED || m_st == ST_BEAM);
    v[4] = v[5];
    v[3] = (m_st == ST_ARMED || m_st == ST_BEAM);
    v[2] = (m_st == ST_COOL || m_st == ST_FAULT || m_flag[0]);
    v[1] = (m_st == ST_BEAM);
    v[0] = (m_st == ST_FAULT);
    return v;
  endfunction

  function automatic logic [5:0] dut_outs();
    return {bif.table_en, bif.gantry_en, bif.filter_en, bif.fan_en, bif.shutter_open, bif.relay_iso};
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_state"}, 32'(bif.state_dbg), 32'(m_st));
    chk({tag, "_code"},  32'(bif.fault_code), 32'(m_code));
    chk({tag, "_outs"},  32'(dut_outs()), 32'(exp_outs()));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input bit xr, input bit pos, input bit dose, input bit pf,
                        input bit temp, input bit vib, input logic [NUM_AUX-1:0] aux, input bit clr);
    bif.xray_req = xr; bif.pos_ok = pos; bif.dose_limit = dose; bif.power_fail = pf;
    bif.temp_hi = temp; bif.vib_hi = vib; bif.aux_fault = aux; bif.fault_clear = clr;
  endtask

  task automatic goto_beam(input string tag);
    set_in(1, 1, 0, 0, 0, 0, '0, 0);
    for (int i = 0; i < 12 && bif.state_dbg != 3'd3; i++) step(tag);
    chk({tag, "_reach_beam"}, 32'(bif.state_dbg), 32'd3);
  endtask

  task automatic back_to_idle(input string tag);
    set_in(0, 1, 0, 0, 0, 0, '0, 1);
    for (int i = 0; i < 40 && bif.state_dbg != 3'd0; i++) step(tag);
    chk({tag, "_reach_idle"}, 32'(bif.state_dbg), 32'd0);
    bif.fault_clear = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, '0, 0);
    #3;
    model_reset();
    chk("reset_state", 32'(bif.state_dbg), 32'd0);
    chk("reset_outs",  32'(dut_outs()), 32'd0);
    chk("reset_code",  32'(bif.fault_code), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Nominal shot
    set_in(1, 1, 0, 0, 0, 0, '0, 0);
    step("nom");
    chk("nom_position", 32'(bif.state_dbg), 32'd1);
    step("nom");
    chk("nom_armed1", 32'(bif.state_dbg), 32'd2);
    step("nom");
    chk("nom_armed2", 32'(bif.state_dbg), 32'd2);
    step("nom");
    chk("nom_beam", 32'(bif.state_dbg), 32'd3);
    chk("nom_shutter", 32'(bif.shutter_open), 32'd1);
    step("nom");
    bif.xray_req = 1'b0;
    step("nom");
    chk("nom_cool_fan", 32'(bif.fan_en), 32'd1);
    n = 0;
    bif.xray_req = 1'b1;
    while (n < 40 && bif.state_dbg == 3'd4) begin step("nom_cool"); n++; end
    chk("nom_cool_len", 32'(n), 32'd16);
    bif.xray_req = 1'b0;
    chk("nom_idle_outs", 32'(dut_outs()), 32'd0);

    // Vibration debounce in BEAM
    goto_beam("vib");
    bif.vib_hi = 1'b1;
    repeat (3) step("vib_short");
    bif.vib_hi = 1'b0;
    repeat (5) step("vib_short");
    chk("vib_short_nofault", 32'(bif.state_dbg), 32'd3);
    bif.vib_hi = 1'b1;
    repeat (4) step("vib_long");
    chk("vib_still_beam", 32'(bif.state_dbg), 32'd3);
    bif.vib_hi = 1'b0;
    step("vib_long");
    chk("vib_fault", 32'(bif.state_dbg), 32'd5);
    chk("vib_code", 32'(bif.fault_code), 32'd2);
    chk("vib_relay_shutter", 32'({bif.relay_iso, bif.shutter_open}), 32'b10);
    back_to_idle("vib_clr");

    // Immediate power fault in ARMED
    set_in(1, 1, 0, 0, 0, 0, '0, 0);
    step("pf"); step("pf");
    chk("pf_armed", 32'(bif.state_dbg), 32'd2);
    bif.power_fail = 1'b1;
    step("pf");
    chk("pf_code", 32'(bif.fault_code), 32'd1);
    set_in(0, 1, 0, 1, 0, 0, '0, 1);
    step("pf_hold");
    chk("pf_hold_state", 32'(bif.state_dbg), 32'd5);
    bif.power_fail = 1'b0;
    step("pf_release");
    chk("pf_release_state", 32'(bif.state_dbg), 32'd0);
    bif.fault_clear = 1'b0;

    // Dose limit, then position loss
    goto_beam("dose");
    bif.dose_limit = 1'b1;
    step("dose");
    chk("dose_cool", 32'(bif.state_dbg), 32'd4);
    back_to_idle("dose_end");
    goto_beam("posl");
    bif.pos_ok = 1'b0;
    step("posl");
    chk("posl_code", 32'(bif.fault_code), 32'd4);
    back_to_idle("posl_clr");

    // Aux fault in IDLE: lowest active bit is 1 -> code 6
    set_in(0, 1, 0, 0, 0, 0, 3'b110, 0);
    repeat (4) step("aux");
    bif.aux_fault = '0;
    step("aux");
    chk("aux_code", 32'(bif.fault_code), 32'd6);
    back_to_idle("aux_clr");

    // Temperature held through COOLDOWN stretches it
    goto_beam("temp");
    bif.xray_req = 1'b0;
    step("temp");
    bif.temp_hi = 1'b1;
    repeat (30) step("temp_hold");
    chk("temp_still_cool", 32'(bif.state_dbg), 32'd4);
    bif.temp_hi = 1'b0;
    back_to_idle("temp_end");

    // Asynchronous reset mid-BEAM
    goto_beam("rst");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_async_shutter", 32'(bif.shutter_open), 32'd0);
    chk("rst_async_state", 32'(bif.state_dbg), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    goto_beam("rst_again");
    bif.xray_req = 1'b0;
    back_to_idle("rst_again_end");

    // Random traffic
    set_in(0, 1, 0, 0, 0, 0, '0, 0);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(15) == 0) bif.xray_req = ~bif.xray_req;
      bif.pos_ok      = ($urandom_range(39) != 0);
      bif.power_fail  = ($urandom_range(99) == 0);
      bif.dose_limit  = ($urandom_range(29) == 0);
      bif.fault_clear = ($urandom_range(3) == 0);
      if ($urandom_range(11) == 0) bif.temp_hi = ~bif.temp_hi;
      if ($urandom_range(23) == 0) bif.vib_hi  = ~bif.vib_hi;
      for (int a = 0; a < NUM_AUX; a++)
        if ($urandom_range(39) == 0) bif.aux_fault[a] = ~bif.aux_fault[a];
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
